mem_access_unit: RTL and testbench

Memory-stage load/store unit of the 5-stage MIPS pipeline. It sits directly downstream of the execute/memory pipeline register. It takes the M-stage address (ALU result), store data and access type, and runs a two-phase request/response data bus. It returns an aligned, sign/zero-extended load word to the writeback register and raises a stall while an access is outstanding.

---
 rtl/mem_defs.sv | 42 ++++
 rtl/mem_align.sv | 52 +++++
 rtl/mem_access_unit.sv | 149 ++++++++++++++
 tb/tb_mem_access_unit.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_defs.sv
// Shared encodings for the memory-stage load/store unit.
// Provides access types, bus size codes, FSM states and alignment helpers.
package mem_defs;

    typedef enum logic [2:0] {
        MT_LB  = 3'b000,
        MT_LBU = 3'b001,
        MT_LH  = 3'b010,
        MT_LHU = 3'b011,
        MT_LW  = 3'b100
    } memtype_e;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    function automatic logic [1:0] size_of(input logic [2:0] mt);
        logic [1:0] sz;
        case (mt)
            MT_LB, MT_LBU: sz = SZ_BYTE;
            MT_LH, MT_LHU: sz = SZ_HALF;
            default:       sz = SZ_WORD;
        endcase
        return sz;
    endfunction

    function automatic logic misaligned(input logic [2:0] mt,
                                        input logic [1:0] off);
        logic [1:0] sz;
        sz = size_of(mt);
        return (sz == SZ_HALF && off[0]) ||
               (sz == SZ_WORD && off != 2'b00);
    endfunction

endpackage

// File: rtl/mem_align.sv
// Byte-lane steering: store replication/strobes and load select/extend.
// Ports: st_* (offset, type, raw data -> wdata, strb); ld_* (offset, type, rdata -> data).
module mem_align
    import mem_defs::*;
(
    input  logic [1:0]  st_off_i,
    input  logic [2:0]  st_type_i,
    input  logic [31:0] st_data_i,
    output logic [31:0] st_wdata_o,
    output logic [3:0]  st_strb_o,
    input  logic [1:0]  ld_off_i,
    input  logic [2:0]  ld_type_i,
    input  logic [31:0] ld_rdata_i,
    output logic [31:0] ld_data_o
);

    logic [31:0] ld_shift;
    logic [7:0]  ld_b;
    logic [15:0] ld_h;

    always_comb begin
        st_wdata_o = st_data_i;
        st_strb_o  = 4'b1111;
        case (size_of(st_type_i))
            SZ_BYTE: begin
                st_wdata_o = {4{st_data_i[7:0]}};
                st_strb_o  = 4'b0001 << st_off_i;
            end
            SZ_HALF: begin
                st_wdata_o = {2{st_data_i[15:0]}};
                st_strb_o  = st_off_i[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase
    end

    // Shift the addressed lane down to bit 0 before extending.
    assign ld_shift = ld_rdata_i >> {ld_off_i, 3'b000};
    assign ld_b     = ld_shift[7:0];
    assign ld_h     = ld_shift[15:0];

    always_comb begin
        case (ld_type_i)
            MT_LB:   ld_data_o = {{24{ld_b[7]}}, ld_b};
            MT_LBU:  ld_data_o = {24'b0, ld_b};
            MT_LH:   ld_data_o = {{16{ld_h[15]}}, ld_h};
            MT_LHU:  ld_data_o = {16'b0, ld_h};
            default: ld_data_o = ld_rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit driving a two-phase req/resp data bus.
// Ports: M-stage access in, readdataM/stallM/adelM/adesM out, data_* bus.
module mem_access_unit
    import mem_defs::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        memenM,
    input  logic        memwriteM,
    input  logic [2:0]  memtypeM,
    input  logic [31:0] addrM,
    input  logic [31:0] writedataM,
    input  logic        flushM,
    input  logic        holdM,
    output logic [31:0] readdataM,
    output logic        stallM,
    output logic        adelM,
    output logic        adesM,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    output logic [3:0]  data_wstrb,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata
);

    state_e      state_q, state_d;
    logic        cancel_q, cancel_d;
    logic [31:0] result_q, result_d;
    logic [31:0] addr_q, wdata_q;
    logic [2:0]  type_q;
    logic        wr_q;

    logic        fault, start, idle, cancel, capture;
    logic [31:0] cur_addr, cur_wdata, st_wdata, ld_data;
    logic [2:0]  cur_type;
    logic        cur_wr;
    logic [3:0]  st_strb;

    assign fault  = memenM & misaligned(memtypeM, addrM[1:0]);
    assign adelM  = fault & ~memwriteM;
    assign adesM  = fault & memwriteM;
    assign start  = memenM & ~flushM & ~fault;
    assign idle   = (state_q == ST_IDLE);
    // A flush seen on the same cycle as the response still drops it.
    assign cancel = cancel_q | flushM;

    // IDLE issues straight from the M stage; later phases replay captures.
    assign cur_addr  = idle ? addrM      : addr_q;
    assign cur_wdata = idle ? writedataM : wdata_q;
    assign cur_type  = idle ? memtypeM   : type_q;
    assign cur_wr    = idle ? memwriteM  : wr_q;

    mem_align u_align (
        .st_off_i   (cur_addr[1:0]),
        .st_type_i  (cur_type),
        .st_data_i  (cur_wdata),
        .st_wdata_o (st_wdata),
        .st_strb_o  (st_strb),
        .ld_off_i   (addr_q[1:0]),
        .ld_type_i  (type_q),
        .ld_rdata_i (data_rdata),
        .ld_data_o  (ld_data)
    );

    assign data_addr  = cur_addr;
    assign data_wdata = st_wdata;
    assign data_wstrb = cur_wr ? st_strb : 4'b0000;
    assign data_size  = size_of(cur_type);
    assign data_wr    = data_req & cur_wr;

    always_comb begin
        state_d   = state_q;
        cancel_d  = cancel_q;
        result_d  = result_q;
        capture   = 1'b0;
        data_req  = 1'b0;
        stallM    = 1'b0;
        readdataM = result_q;
        unique case (state_q)
            ST_IDLE: begin
                cancel_d = 1'b0;
                data_req = start;
                stallM   = start;
                capture  = start;
                if (start) begin
                    state_d = data_addr_ok ? ST_DATA : ST_ADDR;
                end
            end
            ST_ADDR: begin
                data_req = 1'b1;
                stallM   = 1'b1;
                cancel_d = cancel;
                if (data_addr_ok) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                stallM   = 1'b1;
                cancel_d = cancel;
                if (data_data_ok) begin
                    readdataM = ld_data;
                    if (cancel) begin
                        state_d  = ST_IDLE;
                        cancel_d = 1'b0;
                    end else begin
                        stallM = 1'b0;
                        if (!wr_q) begin
                            result_d = ld_data;
                        end
                        state_d = holdM ? ST_DONE : ST_IDLE;
                    end
                end
            end
            ST_DONE: begin
                if (!holdM) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            cancel_q <= 1'b0;
            result_q <= 32'b0;
            addr_q   <= 32'b0;
            wdata_q  <= 32'b0;
            type_q   <= 3'b000;
            wr_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cancel_q <= cancel_d;
            result_q <= result_d;
            if (capture) begin
                addr_q  <= addrM;
                wdata_q <= writedataM;
                type_q  <= memtypeM;
                wr_q    <= memwriteM;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed and random accesses
// against a byte-lane reference model with a scripted bus slave.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        memenM, memwriteM, flushM, holdM;
    logic [2:0]  memtypeM;
    logic [31:0] addrM, writedataM;
    logic [31:0] readdataM;
    logic        stallM, adelM, adesM;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata;
    logic [3:0]  data_wstrb;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;

    mem_access_unit dut (
        .clk          (clk),
        .rst          (rst),
        .memenM       (memenM),
        .memwriteM    (memwriteM),
        .memtypeM     (memtypeM),
        .addrM        (addrM),
        .writedataM   (writedataM),
        .flushM       (flushM),
        .holdM        (holdM),
        .readdataM    (readdataM),
        .stallM       (stallM),
        .adelM        (adelM),
        .adesM        (adesM),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_wstrb   (data_wstrb),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] last_res;

    int          o_nreq, o_nstall, o_rdbad, o_unstable;
    logic        o_to, o_wr;
    logic [3:0]  o_strb;
    logic [31:0] o_wdata, o_addr, o_rd;
    logic [1:0]  o_size;

    // ---------------- reference model ----------------
    function automatic int m_bytes(input logic [2:0] ty);
        if (ty == 3'b000 || ty == 3'b001) return 1;
        if (ty == 3'b010 || ty == 3'b011) return 2;
        return 4;
    endfunction

    function automatic logic [1:0] m_size(input logic [2:0] ty);
        int n;
        n = m_bytes(ty);
        return (n == 1) ? 2'd0 : (n == 2) ? 2'd1 : 2'd2;
    endfunction

    function automatic logic m_fault(input logic [2:0] ty, input logic [31:0] a);
        return (a % m_bytes(ty)) != 0;
    endfunction

    function automatic logic [3:0] m_strb(input logic [2:0] ty, input logic [31:0] a);
        int v;
        v = ((1 << m_bytes(ty)) - 1) << (a % 4);
        return v[3:0];
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] ty, input logic [31:0] d);
        int n;
        n = m_bytes(ty);
        if (n == 1) return {24'b0, d[7:0]} * 32'h01010101;
        if (n == 2) return {16'b0, d[15:0]} * 32'h00010001;
        return d;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] ty, input logic [31:0] a,
                                           input logic [31:0] rd);
        longint v, span;
        int n;
        n = m_bytes(ty);
        if (n == 4) return rd;
        span = longint'(1) << (8 * n);
        v = (longint'(rd) >> (8 * (a % 4))) % span;
        if ((ty == 3'b000 || ty == 3'b010) && v >= span / 2) v = v - span;
        return v[31:0];
    endfunction

    // ---------------- scripted bus transaction ----------------
    // Called at posedge+1; returns at posedge+1 of the cycle after completion.
    task automatic run_txn(input logic wr, input logic [2:0] ty,
                           input logic [31:0] ad, input logic [31:0] wd,
                           input logic [31:0] rd, input int alat, input int dlat,
                           input int hlat, input int fcyc);
        int phase, cnt, hc;
        logic done, first;
        phase = 0; cnt = 0; hc = 0; done = 1'b0; first = 1'b1;
        o_nreq = 0; o_nstall = 0; o_rdbad = 0; o_unstable = 0; o_to = 1'b1;
        o_rd = '0; o_strb = '0; o_wdata = '0; o_addr = '0; o_size = '0; o_wr = 1'b0;
        memenM = 1'b1; memwriteM = wr; memtypeM = ty; addrM = ad; writedataM = wd;
        for (int c = 0; c < 100; c++) begin
            flushM       = (c == fcyc);
            data_addr_ok = (phase == 0) && (cnt == alat);
            data_data_ok = (phase == 1) && (cnt == dlat);
            data_rdata   = data_data_ok ? rd : $urandom;
            if (phase == 1)      holdM = data_data_ok && (hlat > 0);
            else if (phase == 2) holdM = (hc < hlat);
            else                 holdM = 1'b0;
            #4;
            if (data_req) begin
                if (first) begin
                    o_strb = data_wstrb; o_wdata = data_wdata; o_addr = data_addr;
                    o_size = data_size;  o_wr = data_wr; first = 1'b0;
                end else if ({data_wstrb, data_wdata, data_addr, data_size, data_wr} !==
                             {o_strb, o_wdata, o_addr, o_size, o_wr}) begin
                    o_unstable++;
                end
                o_nreq++;
            end
            if (stallM) o_nstall++;
            if (data_data_ok) o_rd = readdataM;
            else if (phase == 2 && readdataM !== o_rd) o_rdbad++;
            if (phase == 0) begin
                if (data_addr_ok) begin phase = 1; cnt = 0; end
                else cnt++;
            end else if (phase == 1) begin
                if (data_data_ok) begin
                    if (holdM && fcyc < 0) begin phase = 2; hc = 1; end
                    else done = 1'b1;
                end else cnt++;
            end else begin
                if (!holdM) done = 1'b1;
                else hc++;
            end
            @(posedge clk); #1;
            if (done) begin o_to = 1'b0; break; end
        end
        memenM = 1'b0; flushM = 1'b0; holdM = 1'b0;
        data_addr_ok = 1'b0; data_data_ok = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        repeat (2) @(posedge clk);
        #4;
        n_cmp++; if (data_req !== 1'b0) begin n_bad++; $display("FAIL reset_req: got %b want 0", data_req); end
        n_cmp++; if (stallM !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %b want 0", stallM); end
        n_cmp++; if ({adelM, adesM} !== 2'b00) begin n_bad++; $display("FAIL reset_ade: got %b want 00", {adelM, adesM}); end
        n_cmp++; if (readdataM !== 32'h0) begin n_bad++; $display("FAIL reset_rdata: got %h want 0", readdataM); end
        rst = 1'b1;
        last_res = 32'h0;
        @(posedge clk); #1;
    endtask

    task automatic test_store_word;
        run_txn(1'b1, 3'b100, 32'h100, 32'h11223344, 32'h0, 0, 3, 0, -1);
        n_cmp++; if (o_to !== 1'b0) begin n_bad++; $display("FAIL sw_timeout: got %b want 0", o_to); end
        n_cmp++; if (o_strb !== 4'b1111) begin n_bad++; $display("FAIL sw_strb: got %b want 1111", o_strb); end
        n_cmp++; if (o_wdata !== 32'h11223344) begin n_bad++; $display("FAIL sw_wdata: got %h want 11223344", o_wdata); end
        n_cmp++; if ({o_wr, o_size, o_addr} !== {1'b1, 2'd2, 32'h100}) begin n_bad++; $display("FAIL sw_bus: got %b %0d %h want 1 2 100", o_wr, o_size, o_addr); end
        n_cmp++; if (o_nstall !== 4) begin n_bad++; $display("FAIL sw_stall: got %0d want 4", o_nstall); end
        n_cmp++; if (o_nreq !== 1) begin n_bad++; $display("FAIL sw_nreq: got %0d want 1", o_nreq); end
    endtask

    task automatic test_load_extend;
        run_txn(1'b0, 3'b000, 32'h103, 32'h0, 32'h80FFFFFF, 0, 0, 0, -1);
        n_cmp++; if (o_rd !== 32'hFFFFFF80) begin n_bad++; $display("FAIL lb: got %h want ffffff80", o_rd); end
        n_cmp++; if (o_strb !== 4'b0000 || o_wr !== 1'b0) begin n_bad++; $display("FAIL lb_strb: got %b/%b want 0000/0", o_strb, o_wr); end
        n_cmp++; if (o_nstall !== 1) begin n_bad++; $display("FAIL lb_stall: got %0d want 1", o_nstall); end
        run_txn(1'b0, 3'b001, 32'h103, 32'h0, 32'h80FFFFFF, 0, 0, 0, -1);
        n_cmp++; if (o_rd !== 32'h00000080) begin n_bad++; $display("FAIL lbu: got %h want 00000080", o_rd); end
        run_txn(1'b0, 3'b010, 32'h102, 32'h0, 32'h80015A5A, 1, 0, 0, -1);
        n_cmp++; if (o_rd !== 32'hFFFF8001) begin n_bad++; $display("FAIL lh: got %h want ffff8001", o_rd); end
        n_cmp++; if (o_size !== 2'd1) begin n_bad++; $display("FAIL lh_size: got %0d want 1", o_size); end
        last_res = 32'hFFFF8001;
        #4;
        n_cmp++; if (readdataM !== last_res) begin n_bad++; $display("FAIL lh_held: got %h want %h", readdataM, last_res); end
        @(posedge clk); #1;
    endtask

    task automatic test_misaligned;
        memenM = 1'b1; memwriteM = 1'b0; memtypeM = 3'b100; addrM = 32'h102;
        #4;
        n_cmp++; if ({adelM, adesM, data_req, stallM} !== 4'b1000) begin n_bad++; $display("FAIL lw_misal: got %b want 1000", {adelM, adesM, data_req, stallM}); end
        @(posedge clk); #1;
        memwriteM = 1'b1; memtypeM = 3'b010; addrM = 32'h101;
        #4;
        n_cmp++; if ({adelM, adesM, data_req, stallM} !== 4'b0100) begin n_bad++; $display("FAIL sh_misal: got %b want 0100", {adelM, adesM, data_req, stallM}); end
        @(posedge clk); #1;
        memenM = 1'b0;
    endtask

    task automatic test_hold;
        run_txn(1'b0, 3'b100, 32'h200, 32'h0, 32'hDEADBEEF, 0, 1, 3, -1);
        n_cmp++; if (o_rd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL hold_rd: got %h want deadbeef", o_rd); end
        n_cmp++; if (o_rdbad !== 0) begin n_bad++; $display("FAIL hold_done_rd: got %0d bad cycles want 0", o_rdbad); end
        n_cmp++; if (o_nreq !== 1) begin n_bad++; $display("FAIL hold_nreq: got %0d want 1", o_nreq); end
        n_cmp++; if (o_nstall !== 2 || o_to !== 1'b0) begin n_bad++; $display("FAIL hold_stall: got %0d/%b want 2/0", o_nstall, o_to); end
        last_res = 32'hDEADBEEF;
    endtask

    task automatic test_back_to_back;
        run_txn(1'b0, 3'b011, 32'h306, 32'h0, 32'hBEEF1234, 0, 0, 0, -1);
        n_cmp++; if (o_rd !== 32'h0000BEEF || o_nreq !== 1) begin n_bad++; $display("FAIL b2b_first: got %h/%0d want 0000beef/1", o_rd, o_nreq); end
        run_txn(1'b1, 3'b000, 32'h302, 32'h000000A5, 32'h0, 0, 0, 0, -1);
        n_cmp++; if (o_strb !== 4'b0100 || o_wdata !== 32'hA5A5A5A5) begin n_bad++; $display("FAIL b2b_sb: got %b %h want 0100 a5a5a5a5", o_strb, o_wdata); end
        n_cmp++; if (o_nreq !== 1 || o_nstall !== 1) begin n_bad++; $display("FAIL b2b_timing: got %0d/%0d want 1/1", o_nreq, o_nstall); end
        last_res = 32'h0000BEEF;
    endtask

    task automatic test_flush;
        run_txn(1'b0, 3'b100, 32'h400, 32'h0, 32'hCAFEF00D, 2, 1, 0, 1);
        n_cmp++; if (o_nreq !== 3 || o_unstable !== 0) begin n_bad++; $display("FAIL flush_req: got %0d/%0d want 3/0", o_nreq, o_unstable); end
        n_cmp++; if (o_nstall !== 5 || o_to !== 1'b0) begin n_bad++; $display("FAIL flush_stall: got %0d/%b want 5/0", o_nstall, o_to); end
        #4;
        n_cmp++; if (readdataM !== last_res) begin n_bad++; $display("FAIL flush_discard: got %h want %h", readdataM, last_res); end
        @(posedge clk); #1;
        run_txn(1'b0, 3'b100, 32'h404, 32'h0, 32'h0BADCAFE, 0, 0, 0, -1);
        n_cmp++; if (o_rd !== 32'h0BADCAFE || o_nreq !== 1 || o_nstall !== 1) begin n_bad++; $display("FAIL flush_next: got %h/%0d/%0d want 0badcafe/1/1", o_rd, o_nreq, o_nstall); end
        last_res = 32'h0BADCAFE;
    endtask

    task automatic test_reset_mid;
        memenM = 1'b1; memwriteM = 1'b0; memtypeM = 3'b100; addrM = 32'h500;
        data_addr_ok = 1'b1;
        #4;
        n_cmp++; if (data_req !== 1'b1) begin n_bad++; $display("FAIL rstmid_req: got %b want 1", data_req); end
        @(posedge clk); #1;
        data_addr_ok = 1'b0;
        #2;
        rst = 1'b0; memenM = 1'b0;
        #1;
        n_cmp++; if ({data_req, stallM} !== 2'b00 || readdataM !== 32'h0) begin n_bad++; $display("FAIL rstmid_abort: got %b %h want 00 0", {data_req, stallM}, readdataM); end
        @(posedge clk); #1;
        rst = 1'b1; data_data_ok = 1'b1; data_rdata = 32'h12345678;
        #4;
        n_cmp++; if ({data_req, stallM} !== 2'b00 || readdataM !== 32'h0) begin n_bad++; $display("FAIL rstmid_late_ok: got %b %h want 00 0", {data_req, stallM}, readdataM); end
        @(posedge clk); #1;
        data_data_ok = 1'b0;
        last_res = 32'h0;
        run_txn(1'b0, 3'b000, 32'h501, 32'h0, 32'h00007F00, 0, 0, 0, -1);
        n_cmp++; if (o_rd !== 32'h0000007F || o_nstall !== 1) begin n_bad++; $display("FAIL rstmid_after: got %h/%0d want 0000007f/1", o_rd, o_nstall); end
        last_res = 32'h0000007F;
    endtask

    task automatic test_random;
        logic        wr;
        logic [2:0]  ty;
        logic [31:0] ad, wd, rd;
        int alat, dlat, hlat, fcyc, exp_stall;
        for (int i = 0; i < 40; i++) begin
            wr = 1'($urandom_range(0, 1));
            ty = wr ? 3'(2 * $urandom_range(0, 2)) : 3'($urandom_range(0, 4));
            ad = $urandom;
            if ($urandom_range(0, 4) != 0) ad = ad - (ad % m_bytes(ty));
            wd = $urandom; rd = $urandom;
            alat = $urandom_range(0, 3); dlat = $urandom_range(0, 3);
            hlat = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
            fcyc = -1;
            if (alat + dlat > 0 && $urandom_range(0, 5) == 0) fcyc = $urandom_range(1, alat + dlat);
            if (m_fault(ty, ad)) begin
                memenM = 1'b1; memwriteM = wr; memtypeM = ty; addrM = ad; writedataM = wd;
                #4;
                n_cmp++; if ({adelM, adesM, data_req, stallM} !== {~wr, wr, 2'b00}) begin n_bad++; $display("FAIL rnd%0d_fault: got %b want %b", i, {adelM, adesM, data_req, stallM}, {~wr, wr, 2'b00}); end
                @(posedge clk); #1;
                memenM = 1'b0;
                continue;
            end
            run_txn(wr, ty, ad, wd, rd, alat, dlat, hlat, fcyc);
            exp_stall = alat + 1 + dlat + ((fcyc >= 0) ? 1 : 0);
            n_cmp++; if (o_to !== 1'b0 || o_nreq !== alat + 1 || o_nstall !== exp_stall) begin n_bad++; $display("FAIL rnd%0d_timing: got to=%b req=%0d stall=%0d want 0 %0d %0d", i, o_to, o_nreq, o_nstall, alat + 1, exp_stall); end
            n_cmp++; if ({o_addr, o_size, o_wr, o_strb} !== {ad, m_size(ty), wr, wr ? m_strb(ty, ad) : 4'b0000}) begin n_bad++; $display("FAIL rnd%0d_bus: got %h %0d %b %b want %h %0d %b %b", i, o_addr, o_size, o_wr, o_strb, ad, m_size(ty), wr, wr ? m_strb(ty, ad) : 4'b0000); end
            if (wr) begin
                n_cmp++; if (o_wdata !== m_wdata(ty, wd)) begin n_bad++; $display("FAIL rnd%0d_wdata: got %h want %h", i, o_wdata, m_wdata(ty, wd)); end
            end else if (fcyc < 0) begin
                n_cmp++; if (o_rd !== m_load(ty, ad, rd) || o_rdbad !== 0) begin n_bad++; $display("FAIL rnd%0d_load: got %h (%0d) want %h", i, o_rd, o_rdbad, m_load(ty, ad, rd)); end
                last_res = m_load(ty, ad, rd);
            end
            if (fcyc >= 0) begin
                #4;
                n_cmp++; if (readdataM !== last_res) begin n_bad++; $display("FAIL rnd%0d_discard: got %h want %h", i, readdataM, last_res); end
                @(posedge clk); #1;
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        memenM = 1'b0; memwriteM = 1'b0; memtypeM = 3'b000;
        addrM = '0; writedataM = '0; flushM = 1'b0; holdM = 1'b0;
        data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = '0;
        last_res = '0;
        test_reset();
        test_store_word();
        test_load_extend();
        test_misaligned();
        test_hold();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
